// File: rtl/dft_frame_sequencer_if.sv
// Bus bundle for the DFT frame sequencer: AFE sample stream, configuration,
// coefficient-memory strobe, accumulation-datapath control and result stream.
//   master : the sequencer's view (drives in_ready, coef_*, acc_*_o, res_*_o, status)
//   slave  : the surrounding environment's view (AFE, datapath, consumer)
interface dft_frame_sequencer_if #(
  parameter int IQ_WIDTH           = 16,
  parameter int ACCUM_WIDTH        = 48,
  parameter int NUM_BINS           = 16,
  parameter int SAMPLE_COUNT_WIDTH = 16
);
  localparam int BIN_W = $clog2(NUM_BINS);

  // control / configuration
  logic                                    start_i;
  logic                                    cfg_continuous_i;
  logic [SAMPLE_COUNT_WIDTH-1:0]           cfg_frame_len_i;
  // AFE sample stream
  logic                                    in_valid_i;
  logic                                    in_ready_o;
  logic [IQ_WIDTH-1:0]                     in_i_i;
  logic [IQ_WIDTH-1:0]                     in_q_i;
  // coefficient memory
  logic [SAMPLE_COUNT_WIDTH-1:0]           coef_addr_o;
  logic                                    coef_req_o;
  // accumulation datapath
  logic                                    acc_start_o;
  logic                                    acc_sample_valid_o;
  logic                                    acc_last_o;
  logic [IQ_WIDTH-1:0]                     acc_i_o;
  logic [IQ_WIDTH-1:0]                     acc_q_o;
  logic                                    acc_done_i;
  logic [NUM_BINS-1:0][ACCUM_WIDTH-1:0]    acc_real_i;
  logic [NUM_BINS-1:0][ACCUM_WIDTH-1:0]    acc_imag_i;
  // result stream
  logic                                    res_valid_o;
  logic                                    res_ready_i;
  logic [BIN_W-1:0]                        res_bin_o;
  logic [ACCUM_WIDTH-1:0]                  res_real_o;
  logic [ACCUM_WIDTH-1:0]                  res_imag_o;
  logic                                    res_last_o;
  // status
  logic                                    busy_o;
  logic [15:0]                             frame_count_o;
  logic                                    cfg_err_o;

  modport master (
    input  start_i, cfg_continuous_i, cfg_frame_len_i,
    input  in_valid_i, in_i_i, in_q_i,
    output in_ready_o,
    output coef_addr_o, coef_req_o,
    output acc_start_o, acc_sample_valid_o, acc_last_o, acc_i_o, acc_q_o,
    input  acc_done_i, acc_real_i, acc_imag_i,
    output res_valid_o, res_bin_o, res_real_o, res_imag_o, res_last_o,
    input  res_ready_i,
    output busy_o, frame_count_o, cfg_err_o
  );

  modport slave (
    output start_i, cfg_continuous_i, cfg_frame_len_i,
    output in_valid_i, in_i_i, in_q_i,
    input  in_ready_o,
    input  coef_addr_o, coef_req_o,
    input  acc_start_o, acc_sample_valid_o, acc_last_o, acc_i_o, acc_q_o,
    output acc_done_i, acc_real_i, acc_imag_i,
    input  res_valid_o, res_bin_o, res_real_o, res_imag_o, res_last_o,
    output res_ready_i,
    input  busy_o, frame_count_o, cfg_err_o
  );
endinterface

// File: rtl/dft_frame_sequencer.sv
// Frame controller for the windowed-DFT accumulation datapath.
// Takes N I/Q samples per frame from the AFE, strobes the coefficient memory
// with the sample index, delays each sample by the memory latency so sample and
// coefficient meet at the datapath, appends PIPE_LAT zero samples to drain the
// multiplier pipeline, waits for the datapath to finish and then streams the
// NUM_BINS accumulator results out one bin per handshake.
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset (shared with the datapath)
//   bus    : dft_frame_sequencer_if.master (config, AFE stream, coefficient
//            strobe, datapath control, result stream, status)
module dft_frame_sequencer #(
  parameter int IQ_WIDTH           = 16,
  parameter int ACCUM_WIDTH        = 48,
  parameter int NUM_BINS           = 16,
  parameter int SAMPLE_COUNT_WIDTH = 16,
  parameter int COEF_LAT           = 1,
  parameter int PIPE_LAT           = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  dft_frame_sequencer_if.master bus
);
  localparam int BW = $clog2(NUM_BINS);
  localparam int FW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [2:0] {IDLE, START, STREAM, FLUSH, WAIT_DONE, DRAIN} state_e;

  typedef struct packed {
    logic                last;
    logic [IQ_WIDTH-1:0] i;
    logic [IQ_WIDTH-1:0] q;
  } dl_t;

  state_e                        state_q;
  logic [SAMPLE_COUNT_WIDTH-1:0] len_q, idx_q;
  logic [FW-1:0]                 flush_q;
  logic [BW-1:0]                 bin_q;
  logic [15:0]                   frame_cnt_q;
  logic                          cfg_err_q;

  logic in_hs, flush_last, res_hs, bin_last;
  logic push_vld;
  dl_t  push_dat;

  // Delay line matching the coefficient-memory read latency; stage COEF_LAT
  // feeds the datapath.
  logic [COEF_LAT:1] vld_pipe;
  dl_t               dat_pipe [COEF_LAT:1];

  assign in_hs      = (state_q == STREAM) && bus.in_valid_i && (idx_q < len_q);
  assign flush_last = (state_q == FLUSH) && (flush_q == FW'(PIPE_LAT - 1));
  assign res_hs     = (state_q == DRAIN) && bus.res_ready_i;
  assign bin_last   = (bin_q == BW'(NUM_BINS - 1));

  // Real samples carry last=0; flush entries are zero data with last on the final one.
  always_comb begin
    push_vld = in_hs || (state_q == FLUSH);
    push_dat = '0;
    if (in_hs) begin
      push_dat.i = bus.in_i_i;
      push_dat.q = bus.in_q_i;
    end else begin
      push_dat.last = flush_last;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      flush_q     <= '0;
      bin_q       <= '0;
      frame_cnt_q <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_i || bus.cfg_continuous_i) begin
            if (bus.cfg_frame_len_i != '0) state_q   <= START;
            else                            cfg_err_q <= 1'b1;
          end
        end
        START: begin
          len_q   <= bus.cfg_frame_len_i;
          idx_q   <= '0;
          flush_q <= '0;
          state_q <= STREAM;
        end
        STREAM: begin
          if (in_hs) begin
            idx_q <= idx_q + 1'b1;
            if (idx_q + 1'b1 == len_q) state_q <= FLUSH;
          end
        end
        FLUSH: begin
          flush_q <= flush_q + 1'b1;
          if (flush_last) state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (bus.acc_done_i) begin
            bin_q   <= '0;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (res_hs) begin
            if (bin_last) begin
              bin_q       <= '0;
              frame_cnt_q <= frame_cnt_q + 16'd1;
              state_q     <= IDLE;
            end else begin
              bin_q <= bin_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 1; s <= COEF_LAT; s++) begin
        vld_pipe[s] <= 1'b0;
        dat_pipe[s] <= '0;
      end
    end else begin
      vld_pipe[1] <= push_vld;
      dat_pipe[1] <= push_dat;
      for (int s = 2; s <= COEF_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        dat_pipe[s] <= dat_pipe[s-1];
      end
    end
  end

  assign bus.in_ready_o  = (state_q == STREAM) && (idx_q < len_q);
  // Flush entries re-read the last coefficient; the data is zero so the
  // address only needs to be a legal one.
  assign bus.coef_req_o  = in_hs || (state_q == FLUSH);
  assign bus.coef_addr_o = in_hs               ? idx_q :
                           (state_q == FLUSH)  ? len_q - 1'b1 : '0;

  assign bus.acc_start_o        = (state_q == START);
  assign bus.acc_sample_valid_o = vld_pipe[COEF_LAT];
  assign bus.acc_last_o         = dat_pipe[COEF_LAT].last;
  assign bus.acc_i_o            = dat_pipe[COEF_LAT].i;
  assign bus.acc_q_o            = dat_pipe[COEF_LAT].q;

  assign bus.res_valid_o = (state_q == DRAIN);
  assign bus.res_bin_o   = bin_q;
  assign bus.res_real_o  = (state_q == DRAIN) ? bus.acc_real_i[bin_q] : '0;
  assign bus.res_imag_o  = (state_q == DRAIN) ? bus.acc_imag_i[bin_q] : '0;
  assign bus.res_last_o  = (state_q == DRAIN) && bin_last;

  assign bus.busy_o        = (state_q != IDLE);
  assign bus.frame_count_o = frame_cnt_q;
  assign bus.cfg_err_o     = cfg_err_q;
endmodule
